exe_01: RTL and testbench
=========================

EXE_01 -- requirements
Module: exe_01

Interface
REQ-001 Parameter STABLE_CYCLES, default 1, is the number of consecutive high samples of p_i that qualify a rising edge; legal range 1..255.
REQ-002 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 p_i  input  1  level input to be monitored.
REQ-005 r_o  output  1  registered one-cycle pulse marking a qualified rising edge of p_i.

Function
REQ-006 The block SHALL be a Moore FSM with states LOW, QUAL, PULSE and HIGH, plus an 8-bit qualification counter.
REQ-007 r_o SHALL be 1 only in state PULSE, decoded from the state register with no combinational path from p_i.
REQ-008 From LOW: p_i=0 stays in LOW; p_i=1 goes to PULSE when STABLE_CYCLES=1, otherwise to QUAL with the counter set to 1.
REQ-009 In QUAL: p_i=0 goes to LOW and clears the counter; p_i=1 increments the counter.
REQ-010 In QUAL, the FSM SHALL go to PULSE on the clock edge where the counter would reach STABLE_CYCLES.
REQ-011 PULSE SHALL last exactly one cycle, then go to HIGH if p_i=1 or to LOW if p_i=0.
REQ-012 In HIGH: p_i=1 stays in HIGH; p_i=0 goes to LOW.
REQ-013 Latency with STABLE_CYCLES=N: if p_i is first sampled high at edge k and held high, r_o is 1 during the cycle after edge k+N-1.
REQ-014 A held-high p_i SHALL produce exactly one pulse; no new pulse until p_i has been sampled low.
REQ-015 With N=1 and p_i toggling every cycle, r_o SHALL pulse every second cycle, i.e. on every rising edge.
REQ-016 The counter SHALL saturate and never wrap.
REQ-017 Unreachable state encodings SHALL recover to LOW on the next clock edge.

Reset
REQ-018 While rst_i=1 at a clock edge: state becomes LOW, counter becomes 0 and r_o is 0 in the following cycle.
REQ-019 Reset SHALL override any transition, including a pulse in progress; a PULSE interrupted by reset is dropped.
REQ-020 If p_i is already high when reset deasserts, this SHALL count as a rising edge: p_i high at the first edge after release is treated as a rising edge and qualified per REQ-008..REQ-010 (pulse after STABLE_CYCLES samples).

Configuration
REQ-021 Macro EXE01_SYNC_EN, when defined, SHALL insert a 2-flop synchronizer on p_i ahead of the FSM.
REQ-022 The synchronizer flops SHALL be reset to 0 by rst_i.
REQ-023 With EXE01_SYNC_EN defined, all latencies in REQ-013 increase by exactly 2 cycles.
REQ-024 Without EXE01_SYNC_EN, p_i feeds the FSM directly.

Verification
REQ-025 Reset check: rst_i=1 for 3 cycles with p_i=0 -> r_o=0 throughout and after release.
REQ-026 Toggle check, N=1, no sync: after reset release, p_i toggles every cycle for 10 cycles -> 5 single-cycle r_o pulses, each in the cycle after p_i is sampled high.
REQ-027 Held-high check, N=1: p_i held 1 for 8 cycles -> exactly one r_o pulse, one cycle after the first high sample; the FSM then stays in HIGH.
REQ-028 Qualification check, N=3: p_i high for 2 cycles, low for 1, then high for 3 -> no pulse for the 2-cycle burst; one pulse after the third high sample of the 3-cycle burst.
REQ-029 Mid-operation reset: rst_i=1 on the edge where PULSE would be entered -> r_o stays 0; with p_i held high afterward, one pulse is produced per REQ-020.
REQ-030 Sync build, EXE01_SYNC_EN defined, N=1: single rising edge of p_i -> r_o pulses 3 cycles after the edge is first presented at p_i.

Source files
------------

// File: rtl/exe_01.sv
// Rising-edge qualifier: pulses r_o for one cycle once p_i has been sampled high
// STABLE_CYCLES times in a row. Define EXE01_SYNC_EN to add a 2-flop synchronizer on p_i.
module exe_01 #(
    parameter int unsigned STABLE_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic p_i,
    output logic r_o
);

    typedef enum logic [2:0] {
        ST_LOW   = 3'b000,
        ST_QUAL  = 3'b001,
        ST_PULSE = 3'b010,
        ST_HIGH  = 3'b100
    } state_t;

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] cnt_inc_s;
    logic       p_s;

`ifdef EXE01_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-stage synchronizer for the asynchronous level input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= p_i;
            sync2_q <= sync1_q;
        end
    end

    assign p_s = sync2_q;
`else
    assign p_s = p_i;
`endif

    // State and qualification counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_LOW;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter saturates at all-ones so a long qualification never wraps.
    assign cnt_inc_s = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOW: begin
                if (p_s) begin
                    cnt_d = 8'd1;
                    if (STABLE_C == 8'd1) begin
                        state_d = ST_PULSE;
                    end else begin
                        state_d = ST_QUAL;
                    end
                end else begin
                    state_d = ST_LOW;
                    cnt_d   = 8'd0;
                end
            end
            ST_QUAL: begin
                if (!p_s) begin
                    state_d = ST_LOW;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc_s;
                    // Enter PULSE on the edge where the count reaches the threshold.
                    if (cnt_inc_s >= STABLE_C) begin
                        state_d = ST_PULSE;
                    end else begin
                        state_d = ST_QUAL;
                    end
                end
            end
            ST_PULSE: begin
                if (p_s) begin
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_LOW;
                    cnt_d   = 8'd0;
                end
            end
            ST_HIGH: begin
                if (p_s) begin
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_LOW;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign r_o = (state_q == ST_PULSE);

endmodule

// File: tb/tb_exe_01.sv
// Randomized bench for exe_01 with three thresholds (1, 3, 255) checked against a
// run-length reference model, plus directed scenarios with hand-computed pulse positions.
module tb_exe_01;

`ifdef EXE01_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int NV [3] = '{1, 3, 255};

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       p_i   = 1'b0;
    logic [2:0] r_o_s;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    exe_01 #(.STABLE_CYCLES(1))   u_n1   (.clk_i(clk_i), .rst_i(rst_i), .p_i(p_i), .r_o(r_o_s[0]));
    exe_01 #(.STABLE_CYCLES(3))   u_n3   (.clk_i(clk_i), .rst_i(rst_i), .p_i(p_i), .r_o(r_o_s[1]));
    exe_01 #(.STABLE_CYCLES(255)) u_n255 (.clk_i(clk_i), .rst_i(rst_i), .p_i(p_i), .r_o(r_o_s[2]));

    // Reference model: length of the current run of high samples seen by the FSM.
    int         run_q [3];
    logic [2:0] exp_q;
    logic [1:0] pipe_q = 2'b00;
    logic       valid_q = 1'b0;
    logic       eff_s;

    assign eff_s = (LAT == 2) ? pipe_q[1] : p_i;

    always @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q  <= 2'b00;
            valid_q <= 1'b1;
            for (int j = 0; j < 3; j++) begin
                run_q[j] <= 0;
                exp_q[j] <= 1'b0;
            end
        end else begin
            pipe_q <= {pipe_q[0], p_i};
            for (int j = 0; j < 3; j++) begin
                if (eff_s) begin
                    run_q[j] <= run_q[j] + 1;
                    exp_q[j] <= (run_q[j] + 1 == NV[j]);
                end else begin
                    run_q[j] <= 0;
                    exp_q[j] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (valid_q) begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (r_o_s[j] !== exp_q[j]) begin
                    errors++;
                    $display("FAIL model_cmp N=%0d t=%0t: r_o=%b expected %b", NV[j], $time, r_o_s[j], exp_q[j]);
                end
            end
        end
    end

    // Pulse bookkeeping for directed scenarios.
    int idx;
    int pc [3];
    int pf [3];

    task automatic clr();
        idx = 0;
        for (int j = 0; j < 3; j++) begin
            pc[j] = 0;
            pf[j] = 0;
        end
    endtask

    task automatic tick(input logic r, input logic p);
        rst_i = r;
        p_i   = p;
        @(negedge clk_i);
        idx++;
        for (int j = 0; j < 3; j++) begin
            if (r_o_s[j] === 1'b1) begin
                pc[j]++;
                if (pf[j] == 0) pf[j] = idx;
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    initial begin
        logic lvl;
        logic rr;
        // Reset held for 3 cycles with p low, then released
        clr();
        repeat (3) begin
            tick(1'b1, 1'b0);
            chk("reset_hold_r_o", int'(r_o_s), 0);
        end
        repeat (3) begin
            tick(1'b0, 1'b0);
            chk("after_release_r_o", int'(r_o_s), 0);
        end

        // Toggle every cycle for 10 cycles
        clr();
        for (int i = 0; i < 10; i++) tick(1'b0, (i % 2) == 0);
        repeat (LAT + 2) tick(1'b0, 1'b0);
        chk("toggle_n1_count", pc[0], 5);
        chk("toggle_n1_first", pf[0], 1 + LAT);
        chk("toggle_n3_count", pc[1], 0);

        // Held high for 8 cycles
        repeat (3) tick(1'b0, 1'b0);
        clr();
        repeat (8) tick(1'b0, 1'b1);
        chk("held_n1_count_during", pc[0], 1);
        repeat (LAT + 2) tick(1'b0, 1'b0);
        chk("held_n1_count", pc[0], 1);
        chk("held_n1_first", pf[0], 1 + LAT);
        chk("held_n3_count", pc[1], 1);
        chk("held_n3_first", pf[1], 3 + LAT);

        // Qualification: high 2, low 1, high 3
        repeat (3) tick(1'b0, 1'b0);
        clr();
        tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b0);
        tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b1);
        repeat (LAT + 2) tick(1'b0, 1'b0);
        chk("qual_n3_count", pc[1], 1);
        chk("qual_n3_first", pf[1], 6 + LAT);
        chk("qual_n1_count", pc[0], 2);
        chk("qual_n1_first", pf[0], 1 + LAT);

        // Reset on the edge where PULSE would be entered, p held high afterwards
        repeat (3) tick(1'b0, 1'b0);
        clr();
        tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b1, 1'b1);
        repeat (6) tick(1'b0, 1'b1);
        chk("midreset_n3_count", pc[1], 1);
        chk("midreset_n3_first", pf[1], 6 + LAT);

        // Threshold 255: one pulse, counter must not wrap into a second one
        repeat (3) tick(1'b0, 1'b0);
        clr();
        repeat (300) tick(1'b0, 1'b1);
        chk("sat_n255_count", pc[2], 1);
        chk("sat_n255_first", pf[2], 255 + LAT);
        chk("sat_n3_count", pc[1], 1);
        repeat (3) tick(1'b0, 1'b0);

        // Random levels with occasional resets, checked by the model
        lvl = 1'b0;
        repeat (3000) begin
            if ($urandom_range(3, 0) == 0) lvl = ~lvl;
            rr = ($urandom_range(63, 0) == 0);
            tick(rr, lvl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
